// File: rtl/div_ctrl_pkg.sv
// Shared state type and constants for the iterative-divider control FSM.
// StErr is only present when DIV_BY_ZERO_CHECK_EN is defined.
package div_ctrl_pkg;

    localparam int unsigned ITERS_DEFAULT = 14;
    // External counter preset so that its carry-out fires on the last iteration.
    localparam int unsigned CNT_INIT      = 16 - ITERS_DEFAULT;

`ifdef DIV_BY_ZERO_CHECK_EN
    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StCalc,
        StDone,
        StErr
    } state_e;
`else
    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCalc,
        StDone
    } state_e;
`endif

endpackage

// File: rtl/div_controller.sv
// Control FSM for a restoring divider; the iteration counter is an external instance.
// Define DIV_BY_ZERO_CHECK_EN to add the divide-by-zero error state (ERR, dvz flag).
module div_controller
    import div_ctrl_pkg::*;
#(
    parameter int unsigned ITERS = ITERS_DEFAULT,
    parameter int unsigned CNT_W = 4
) (
    input  logic clk,
    input  logic sclr,
    input  logic start,
    input  logic rem_neg,
    input  logic b_zero,
    input  logic cnt_co,
    output logic ld_a,
    output logic ld_b,
    output logic cnt_iz,
    output logic cnt_en,
    output logic sh_en,
    output logic wr_rem,
    output logic q_in,
    output logic ready,
    output logic busy,
    output logic done,
    output logic dvz
);

    if (ITERS < 1 || ITERS > 15) begin : g_bad_iters
        $error("div_controller: ITERS must be in 1..15");
    end
    if (CNT_W < 4) begin : g_bad_cnt_w
        $error("div_controller: CNT_W must be at least 4");
    end

    state_e state_q, state_d;

    always_ff @(posedge clk) begin
        if (sclr) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ld_a    = 1'b0;
        ld_b    = 1'b0;
        cnt_iz  = 1'b0;
        cnt_en  = 1'b0;
        sh_en   = 1'b0;
        wr_rem  = 1'b0;
        q_in    = 1'b0;
        ready   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        dvz     = 1'b0;
        unique case (state_q)
            StIdle: begin
                ready = 1'b1;
                if (start) state_d = StLoad;
            end
            StLoad: begin
                ld_a   = 1'b1;
                ld_b   = 1'b1;
                cnt_iz = 1'b1;
`ifdef DIV_BY_ZERO_CHECK_EN
                state_d = b_zero ? StErr : StCalc;
`else
                state_d = StCalc;
`endif
            end
            StCalc: begin
                cnt_en = 1'b1;
                sh_en  = 1'b1;
                busy   = 1'b1;
                // Non-negative trial remainder: keep it and shift in a 1.
                wr_rem = ~rem_neg;
                q_in   = ~rem_neg;
                if (cnt_co) state_d = StDone;
            end
            StDone: begin
                done = 1'b1;
                if (!start) state_d = StIdle;
            end
`ifdef DIV_BY_ZERO_CHECK_EN
            StErr: begin
                done = 1'b1;
                dvz  = 1'b1;
                if (!start) state_d = StIdle;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

`ifndef DIV_BY_ZERO_CHECK_EN
    logic unused_b_zero;
    assign unused_b_zero = b_zero;
`endif

endmodule

// File: tb/tb_div_controller.sv
// Scoreboard bench for div_controller: two instances (ITERS=14 and ITERS=1) share stimulus,
// each paired with a behavioural 4-bit counter; a negedge monitor checks against queued results.
module tb_div_controller;
    import div_ctrl_pkg::*;

    localparam int NDUT    = 2;
    localparam int ITERS_A = 14;
    localparam int ITERS_B = 1;
    localparam logic [10:0] READY_ONLY = 11'b000_0000_1000;
    localparam logic [10:0] LOAD_ONLY  = 11'b111_0000_0000;

    typedef struct {
        int   done_cyc;
        int   calc;
        logic dvz;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic sclr, start, rem_neg, b_zero;
    logic [3:0] cnt [NDUT];
    logic cnt_co [NDUT];
    logic ld_a [NDUT], ld_b [NDUT], cnt_iz [NDUT], cnt_en [NDUT], sh_en [NDUT];
    logic wr_rem [NDUT], q_in [NDUT], ready [NDUT], busy [NDUT], done [NDUT], dvz [NDUT];

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic mon_en = 1'b0;
    exp_t exp_q0 [$];
    exp_t exp_q1 [$];
    int   calc_cnt [NDUT];
    logic done_prev [NDUT];

    div_controller #(.ITERS(ITERS_A), .CNT_W(4)) u_dut_a (
        .clk(clk), .sclr(sclr), .start(start), .rem_neg(rem_neg), .b_zero(b_zero),
        .cnt_co(cnt_co[0]), .ld_a(ld_a[0]), .ld_b(ld_b[0]), .cnt_iz(cnt_iz[0]),
        .cnt_en(cnt_en[0]), .sh_en(sh_en[0]), .wr_rem(wr_rem[0]), .q_in(q_in[0]),
        .ready(ready[0]), .busy(busy[0]), .done(done[0]), .dvz(dvz[0])
    );

    div_controller #(.ITERS(ITERS_B), .CNT_W(4)) u_dut_b (
        .clk(clk), .sclr(sclr), .start(start), .rem_neg(rem_neg), .b_zero(b_zero),
        .cnt_co(cnt_co[1]), .ld_a(ld_a[1]), .ld_b(ld_b[1]), .cnt_iz(cnt_iz[1]),
        .cnt_en(cnt_en[1]), .sh_en(sh_en[1]), .wr_rem(wr_rem[1]), .q_in(q_in[1]),
        .ready(ready[1]), .busy(busy[1]), .done(done[1]), .dvz(dvz[1])
    );

    // External counters: preset to 16-ITERS, carry-out while the count is 15.
    always @(posedge clk) begin
        if (cnt_iz[0]) cnt[0] <= 4'(CNT_INIT);
        else if (cnt_en[0]) cnt[0] <= cnt[0] + 4'd1;
        if (cnt_iz[1]) cnt[1] <= 4'(16 - ITERS_B);
        else if (cnt_en[1]) cnt[1] <= cnt[1] + 4'd1;
    end
    assign cnt_co[0] = (cnt[0] == 4'd15);
    assign cnt_co[1] = (cnt[1] == 4'd15);

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [10:0] outs(input int d);
        return {ld_a[d], ld_b[d], cnt_iz[d], cnt_en[d], sh_en[d], wr_rem[d], q_in[d],
                ready[d], busy[d], done[d], dvz[d]};
    endfunction

    task automatic check(input string name, input int act, input int want);
        total++;
        if (act != want) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, want, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Raise start for one operation and queue what each instance should report.
    // The sampling edge opens cycle 1 (LOAD); DONE appears in cycle ITERS+2, ERR in cycle 2.
    task automatic start_op(input logic bz);
        exp_t e;
        int   s;
        logic err;
        s = cyc + 1;
`ifdef DIV_BY_ZERO_CHECK_EN
        err = bz;
`else
        err = 1'b0;
`endif
        b_zero = bz;
        start  = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            int it;
            it = (d == 0) ? ITERS_A : ITERS_B;
            e.done_cyc = err ? s + 1 : s + it + 1;
            e.calc     = err ? 0 : it;
            e.dvz      = err;
            if (d == 0) exp_q0.push_back(e);
            else exp_q1.push_back(e);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            rem_neg = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        logic [10:0] want;
        logic got_exp;
        for (int d = 0; d < NDUT; d++) begin
            if (mon_en) begin
                check($sformatf("one_state_%0d", d),
                      $countones({ready[d], ld_a[d], busy[d], done[d]}), 1);
                if (ready[d]) check($sformatf("idle_outs_%0d", d), outs(d), READY_ONLY);
                if (ld_a[d]) begin
                    check($sformatf("load_outs_%0d", d), outs(d), LOAD_ONLY);
                    calc_cnt[d] = 0;
                end
                if (busy[d]) begin
                    want = {3'b000, 1'b1, 1'b1, ~rem_neg, ~rem_neg, 1'b0, 1'b1, 2'b00};
                    check($sformatf("calc_outs_%0d", d), outs(d), want);
                    calc_cnt[d]++;
                end
                if (done[d]) check($sformatf("done_outs_%0d", d), outs(d) & 11'h7fc, 0);
                if (done[d] && !done_prev[d]) begin
                    got_exp = (d == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
                    if (!got_exp) begin
                        check($sformatf("unexpected_done_%0d", d),
                              (d == 0) ? exp_q0.size() : exp_q1.size(), 1);
                    end else begin
                        e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check($sformatf("done_cycle_%0d", d), cyc, e.done_cyc);
                        check($sformatf("calc_cycles_%0d", d), calc_cnt[d], e.calc);
                        check($sformatf("dvz_%0d", d), 32'(dvz[d]), 32'(e.dvz));
                    end
                end
            end
            done_prev[d] = done[d];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sclr    = 1'b1;
        start   = 1'b0;
        b_zero  = 1'b0;
        rem_neg = 1'b0;
        tick(2);
        sclr = 1'b0;
        for (int d = 0; d < NDUT; d++) check($sformatf("reset_%0d", d), outs(d), READY_ONLY);
        mon_en = 1'b1;

        // Single start pulse.
        start_op(1'b0);
        tick(1);
        start = 1'b0;
        tick(20);

        // Start held for 30 cycles: one operation, done held until start drops.
        start_op(1'b0);
        tick(30);
        for (int d = 0; d < NDUT; d++) check($sformatf("done_held_%0d", d), 32'(done[d]), 1);
        start = 1'b0;
        tick(1);
        for (int d = 0; d < NDUT; d++) check($sformatf("ready_after_%0d", d), 32'(ready[d]), 1);
        tick(3);

        // Synchronous clear in the 7th CALC cycle aborts the operation.
        start_op(1'b0);
        tick(1);
        start = 1'b0;
        tick(7);
        check("calc7_busy", 32'(busy[0]), 1);
        sclr = 1'b1;
        exp_q0.delete();
        exp_q1.delete();
        tick(1);
        sclr = 1'b0;
        for (int d = 0; d < NDUT; d++) check($sformatf("abort_%0d", d), outs(d), READY_ONLY);
        start_op(1'b0);
        tick(1);
        start = 1'b0;
        tick(20);

        // sclr and start at the same edge: reset wins, no load.
        sclr  = 1'b1;
        start = 1'b1;
        tick(1);
        sclr  = 1'b0;
        start = 1'b0;
        for (int d = 0; d < NDUT; d++) check($sformatf("sclr_wins_%0d", d), 32'(ld_a[d]), 0);
        tick(3);
        for (int d = 0; d < NDUT; d++) check($sformatf("still_idle_%0d", d), outs(d), READY_ONLY);

        // Divisor zero at LOAD.
        start_op(1'b1);
        tick(1);
        start = 1'b0;
        tick(1);
`ifdef DIV_BY_ZERO_CHECK_EN
        check("err_outs", outs(0), 11'b000_0000_0011);
`else
        check("no_err_calc", 32'(busy[0]), 1);
`endif
        tick(20);
        b_zero = 1'b0;

        // Randomised operations with random start hold length and divisor-zero flag.
        for (int i = 0; i < 8; i++) begin
            int hold;
            hold = $urandom_range(1, 4);
            start_op(1'($urandom_range(0, 1)));
            tick(hold);
            start = 1'b0;
            tick(20 + $urandom_range(0, 3));
            b_zero = 1'b0;
        end

        tick(5);
        check("pending_a", exp_q0.size(), 0);
        check("pending_b", exp_q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_controller.md
DIV_CONTROLLER -- requirements
Module: div_controller

Interface
REQ-001 The block SHALL have parameter ITERS, default 14, meaning iterations per operation; it SHALL be legal for 1..15 only.
REQ-002 The block SHALL have parameter CNT_W, default 4, meaning the width of the external iteration counter.
REQ-003 The block SHALL have port clk  input  1  meaning the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port sclr  input  1  meaning a synchronous, active-high reset.
REQ-005 The block SHALL have port start  input  1  meaning the operation request level.
REQ-006 The block SHALL have port rem_neg  input  1  meaning the datapath trial remainder is negative this cycle.
REQ-007 The block SHALL have port b_zero  input  1  meaning the divisor register is zero.
REQ-008 The block SHALL have port cnt_co  input  1  meaning the external counter's carry-out.
REQ-009 The block SHALL have output ports ld_a, ld_b, cnt_iz, cnt_en, sh_en, wr_rem and q_in, each 1 bit, meaning the datapath load, counter-init, counter-enable, shift, remainder-write and quotient-bit controls.
REQ-010 The block SHALL have output ports ready, busy, done and dvz, each 1 bit, meaning the status flags.

Function
REQ-011 The FSM SHALL have exactly the states IDLE, LOAD, CALC, DONE, plus ERR when the REQ-025 macro is defined.
REQ-012 IDLE: ready=1 and all other outputs are 0; start=1 SHALL move the FSM to LOAD.
REQ-013 LOAD: ld_a=ld_b=cnt_iz=1 for exactly one cycle; the next state SHALL be CALC.
REQ-014 CALC: cnt_en=sh_en=busy=1; wr_rem=q_in=!rem_neg, combinationally (Mealy).
REQ-015 CALC: cnt_co=1 SHALL move the FSM to DONE; that cycle is still a full iteration.
REQ-016 The external counter is initialised by cnt_iz to 16-ITERS, so CALC SHALL last exactly ITERS cycles (14 by default).
REQ-017 DONE: done=1; the FSM SHALL stay in DONE while start=1 and return to IDLE on the first cycle with start=0, so a held start never retriggers.
REQ-018 start SHALL be ignored in every state except IDLE and DONE.
REQ-019 rem_neg and cnt_co SHALL be ignored outside CALC.
REQ-020 Outputs not listed for a state SHALL be 0 in that state.
REQ-021 Latency: from the edge that samples start=1 in IDLE, done SHALL go high after ITERS+2 cycles (16 by default).

Reset
REQ-022 sclr=1 at a rising edge SHALL force IDLE in any state, including mid-CALC.
REQ-023 After reset, ready=1 and every other output SHALL be 0 in the next cycle.
REQ-024 sclr SHALL take priority over start when both are high at the same edge; there is no asynchronous path.

Configuration
REQ-025 The macro DIV_BY_ZERO_CHECK_EN SHALL control divide-by-zero checking.
REQ-026 When DIV_BY_ZERO_CHECK_EN is defined: in LOAD, b_zero=1 SHALL move the FSM to ERR instead of CALC.
REQ-027 ERR: dvz=1 and done=1, no datapath strobes; exit to IDLE on the first cycle with start=0.
REQ-028 When DIV_BY_ZERO_CHECK_EN is undefined: b_zero SHALL be unused, ERR SHALL not exist, and dvz SHALL be tied to 0.

Structure
REQ-029 A shared package div_ctrl_pkg SHALL hold the state enum, ITERS_DEFAULT=14 and CNT_INIT=16-ITERS_DEFAULT.
REQ-030 The block SHALL be a single module with no sub-module; the iteration counter remains an external instance driven through cnt_iz, cnt_en and cnt_co.

Verification
REQ-031 The bench SHALL cover these scenarios, each paired with a behavioural 4-bit counter model (init 2, co at 15):
- start pulse with rem_neg random -> LOAD 1 cycle, exactly 14 CALC cycles, done at cycle 16, q_in == !rem_neg in each CALC cycle.
- start held high for 30 cycles -> one operation only; done stays high until start=0, then ready=1 the next cycle.
- sclr asserted in the 7th CALC cycle -> next cycle ready=1 with all strobes 0; a new start gives a full 14-iteration run.
- sclr and start both high at the same edge -> IDLE retained, ld_a=0.
- macro defined, b_zero=1 at LOAD -> ERR with dvz=done=1, zero CALC cycles.
- macro undefined, b_zero=1 -> normal 14-iteration run with dvz=0.
- ITERS=1 -> exactly 1 CALC cycle, done at cycle 3.
